// File: rtl/park_pkg.sv
// Shared definitions for the parking-gate arbiter: FSM encoding and default capacity.
package park_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OPEN  = 2'b01,
    ST_CLOSE = 2'b10
  } park_state_t;

  localparam int DEFAULT_CAPACITY = 4;

endpackage

// File: rtl/park_rr_arbiter.sv
// Combinational round-robin picker: the first requesting lane at or after the pointer wins.
module park_rr_arbiter #(
  parameter int N_LANES = 2,
  parameter int PTR_W   = 1
) (
  input  logic [N_LANES-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [N_LANES-1:0] winner,
  output logic               valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_LANES; i++) begin
      idx = int'(pointer) + i;
      if (idx >= N_LANES) idx = idx - N_LANES;
      for (int j = 0; j < N_LANES; j++) begin
        if (!valid && (j == idx) && req[j]) begin
          winner[j] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/park_gate_arbiter.sv
// Shared-barrier parking gate: round-robin lane grant, open window with timeout, occupancy count.
// Optional macro PARK_RESERVE_LANE0_EN keeps the last free spot for lane 0 only.
module park_gate_arbiter
  import park_pkg::*;
#(
  parameter int N_LANES     = 2,
  parameter int CAPACITY    = DEFAULT_CAPACITY,
  parameter int OPEN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] req,
  input  logic [N_LANES-1:0] pass,
  input  logic               exit_evt,
  output logic [N_LANES-1:0] grant,
  output logic               barrier_open,
  output logic               timeout_err,
  output logic [3:0]         spots_free,
  output logic               full,
  output logic [1:0]         state
);

  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  park_state_t        state_q, state_d;
  logic [N_LANES-1:0] grant_q, grant_d;
  logic               barrier_q, barrier_d;
  logic               timeout_q, timeout_d;
  logic [3:0]         timer_q, timer_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         occ_q, occ_d;

  logic [N_LANES-1:0] elig;
  logic [N_LANES-1:0] win;
  logic               win_vld;
  logic               car_in;
  int                 win_idx;

  assign spots_free   = 4'(CAPACITY) - occ_q;
  assign full         = (spots_free == 4'd0);
  assign grant        = grant_q;
  assign barrier_open = barrier_q;
  assign timeout_err  = timeout_q;
  assign state        = state_q;

`ifdef PARK_RESERVE_LANE0_EN
  always_comb begin
    elig    = {N_LANES{spots_free > 4'd1}};
    elig[0] = (spots_free != 4'd0);
  end
`else
  assign elig = {N_LANES{spots_free != 4'd0}};
`endif

  park_rr_arbiter #(
    .N_LANES (N_LANES),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (req & elig),
    .pointer (ptr_q),
    .winner  (win),
    .valid   (win_vld)
  );

  always_comb begin
    win_idx = 0;
    for (int j = 0; j < N_LANES; j++) begin
      if (win[j]) win_idx = j;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    barrier_d = barrier_q;
    timeout_d = 1'b0;
    timer_d   = timer_q;
    ptr_d     = ptr_q;
    car_in    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d   = '0;
        barrier_d = 1'b0;
        if (win_vld) begin
          grant_d   = win;
          barrier_d = 1'b1;
          timer_d   = 4'd0;
          ptr_d     = (win_idx == N_LANES - 1) ? '0 : PTR_W'(win_idx + 1);
          state_d   = ST_OPEN;
        end
      end
      ST_OPEN: begin
        // A pass on the expiry cycle takes priority over the timeout.
        if (|(pass & grant_q)) begin
          car_in    = 1'b1;
          grant_d   = '0;
          barrier_d = 1'b0;
          state_d   = ST_CLOSE;
        end else if (timer_q == 4'(OPEN_CYCLES - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          barrier_d = 1'b0;
          state_d   = ST_CLOSE;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      ST_CLOSE: begin
        grant_d   = '0;
        barrier_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        grant_d   = '0;
        barrier_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (car_in && exit_evt) begin
      occ_d = occ_q;
    end else if (car_in && (occ_q < 4'(CAPACITY))) begin
      occ_d = occ_q + 4'd1;
    end else if (exit_evt && (occ_q != 4'd0)) begin
      occ_d = occ_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      barrier_q <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= 4'd0;
      ptr_q     <= '0;
      occ_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      barrier_q <= barrier_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: doc/park_gate_arbiter.md
PARK_GATE_ARBITER -- requirements
Module: park_gate_arbiter

Interface
REQ-001 SHALL have parameter N_LANES, 2, number of entry lanes sharing one barrier (2..8).
REQ-002 SHALL have parameter CAPACITY, 4, total parking spots (1..15).
REQ-003 SHALL have parameter OPEN_CYCLES, 8, barrier-open window in clocks before timeout (>=2).
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req, input, N_LANES, per-lane "credentialed car waiting" level.
REQ-007 SHALL have port pass, input, N_LANES, per-lane "car cleared barrier" one-cycle pulse.
REQ-008 SHALL have port exit_evt, input, 1, one-cycle pulse, car left the park.
REQ-009 SHALL have port grant, output, N_LANES, one-hot lane currently served (registered).
REQ-010 SHALL have port barrier_open, output, 1, barrier raised (registered).
REQ-011 SHALL have port timeout_err, output, 1, one-cycle pulse on unused grant (registered).
REQ-012 SHALL have port spots_free, output, 4, CAPACITY minus occupancy.
REQ-013 SHALL have port full, output, 1, high when spots_free == 0.
REQ-014 SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-015 SHALL implement FSM IDLE=00, OPEN=01, CLOSE=10; encoding 11 unreachable and SHALL recover to IDLE next cycle.
REQ-016 IDLE: if any req bit high and grant-eligible (REQ-024), SHALL select winner round-robin, assert grant[winner] and barrier_open on the next edge, enter OPEN.
REQ-017 Round-robin: search starts at pointer; pointer SHALL become winner+1 (mod N_LANES) on each grant.
REQ-018 Latency: req sampled high in IDLE at edge t -> grant/barrier_open high after edge t+1.
REQ-019 OPEN: grant and barrier_open held constant; req changes ignored; 4-bit timer counts from 0.
REQ-020 OPEN, pass[winner]=1: occupancy +1, enter CLOSE; pass on non-granted lanes SHALL be ignored in every state.
REQ-021 OPEN, timer == OPEN_CYCLES-1 without pass: timeout_err pulse, occupancy unchanged, enter CLOSE; pass on same cycle as expiry SHALL win (counted, no error).
REQ-022 CLOSE: grant=0, barrier_open=0 for exactly one cycle, then IDLE; no grant issued from CLOSE.
REQ-023 exit_evt SHALL decrement occupancy in any state when occupancy > 0; at 0 ignored.
REQ-024 Lane eligible only when spots_free > 0; when full, req SHALL be held off in IDLE with no grant.
REQ-025 Simultaneous pass and exit_evt: occupancy unchanged.
REQ-026 Occupancy SHALL never exceed CAPACITY; spots_free and full combinational from occupancy register.

Reset
REQ-027 On rst low, asynchronously: state IDLE, grant 0, barrier_open 0, timeout_err 0, timer 0, pointer 0, occupancy 0 (spots_free=CAPACITY, full=0).
REQ-028 Reset asserted mid-OPEN SHALL drop barrier immediately; in-flight car not counted.

Configuration
REQ-029 Macro PARK_RESERVE_LANE0_EN: when defined, lane 0 eligible when spots_free > 0, other lanes only when spots_free > 1 (last spot reserved for lane 0).
REQ-030 Without PARK_RESERVE_LANE0_EN all lanes SHALL use REQ-024 eligibility unchanged.

Structure
REQ-031 Shared package park_pkg SHALL hold the state typedef/encodings and default CAPACITY constant.
REQ-032 Round-robin selection SHALL be a sub-module park_rr_arbiter (req, pointer in; one-hot winner, valid out; combinational).

Verification
REQ-033 N_LANES=2, req=2'b11 from reset -> grant=01 at cycle 2, pass[0] -> CLOSE; next grant=10 two cycles later.
REQ-034 Grant lane 1, no pass for 8 cycles -> timeout_err single pulse, spots_free stays 4, state returns IDLE.
REQ-035 Four accepted cars -> full=1, spots_free=0; further req=01 -> no grant; exit_evt -> spots_free=1, grant follows.
REQ-036 occupancy 2, pass[winner] and exit_evt same cycle -> spots_free remains 2.
REQ-037 rst low during OPEN -> barrier_open=0 same cycle, occupancy 0, pointer 0.
REQ-038 PARK_RESERVE_LANE0_EN, spots_free=1, req=2'b10 -> no grant; req=2'b11 -> grant=01.
